// File: rtl/pc_update_unit_if.sv
// Fetch/resolve bus for the PC update unit.
// The master modport is the PC unit: it consumes the fetch handshake and the
// resolved control signals, and produces the fetch address, flush, align
// error and the branch statistics. The slave modport is the surrounding
// pipeline and instruction memory.
interface pc_update_unit_if #(
  parameter int unsigned CNT_W = 16
);
  logic             fetch_ready_i;
  logic             stall_i;
  logic             resolve_valid_i;
  logic             branch_i;
  logic             branch_result_i;
  logic             jump_i;
  logic             jr_i;
  logic [31:0]      imm_i;
  logic [25:0]      jump_target_i;
  logic [31:0]      rs_data_i;
  logic [31:0]      pc_o;
  logic             fetch_valid_o;
  logic             flush_o;
  logic             align_err_o;
  logic [CNT_W-1:0] taken_cnt_o;
  logic [CNT_W-1:0] not_taken_cnt_o;

  modport master (
    input  fetch_ready_i, stall_i, resolve_valid_i, branch_i, branch_result_i,
           jump_i, jr_i, imm_i, jump_target_i, rs_data_i,
    output pc_o, fetch_valid_o, flush_o, align_err_o, taken_cnt_o, not_taken_cnt_o
  );

  modport slave (
    output fetch_ready_i, stall_i, resolve_valid_i, branch_i, branch_result_i,
           jump_i, jr_i, imm_i, jump_target_i, rs_data_i,
    input  pc_o, fetch_valid_o, flush_o, align_err_o, taken_cnt_o, not_taken_cnt_o
  );
endinterface

// File: rtl/pc_update_unit.sv
// Program-counter stage after the branch-decision mux.
// Computes the next PC from the branch/jump/jr controls, holds the PC register
// and presents it to instruction memory with a valid/ready handshake. A
// redirect resolved while fetch cannot advance is buffered (latest wins) and
// applied on the next advance; every applied redirect pulses flush_o.
// Optional macro PC_BRANCH_STATS_EN enables saturating taken/not-taken
// counters; without it both counter outputs are tied to 0.
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - asynchronous active-low reset
//   bus    - pc_update_unit_if.master (fetch handshake, resolve controls,
//            pc_o, fetch_valid_o, flush_o, align_err_o, counters)
module pc_update_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  pc_update_unit_if.master bus
);

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    PENDING = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_q, pend_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic        flush_q, flush_d;
  logic        align_err_q, align_err_d;

  logic [31:0] pc4_c;
  logic [31:0] br_tgt_c;
  logic [31:0] j_tgt_c;
  logic [31:0] jr_tgt_c;
  logic [31:0] target_c;
  logic        redirect_c;
  logic        advance_c;

  // Candidate targets, all wrapping mod 2^32
  assign pc4_c    = pc_q + 32'd4;
  assign br_tgt_c = pc4_c + (bus.imm_i << 2);
  assign j_tgt_c  = {pc4_c[31:28], bus.jump_target_i, 2'b00};
  assign jr_tgt_c = {bus.rs_data_i[31:2], 2'b00};

  assign redirect_c = bus.resolve_valid_i &
                      (bus.jr_i | bus.jump_i | (bus.branch_i & bus.branch_result_i));
  assign advance_c  = fetch_valid_q & bus.fetch_ready_i & ~bus.stall_i;

  // jr beats jump beats taken branch
  always_comb begin
    if (bus.jr_i)        target_c = jr_tgt_c;
    else if (bus.jump_i) target_c = j_tgt_c;
    else                 target_c = br_tgt_c;
  end

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_d        = pend_q;
    fetch_valid_d = fetch_valid_q;
    flush_d       = 1'b0;
    align_err_d   = bus.resolve_valid_i & bus.jr_i & (|bus.rs_data_i[1:0]);

    unique case (state_q)
      BOOT: begin
        state_d       = RUN;
        fetch_valid_d = 1'b1;
      end
      RUN: begin
        if (advance_c) begin
          if (redirect_c) begin
            pc_d    = target_c;
            flush_d = 1'b1;
          end else begin
            pc_d = pc4_c;
          end
        end else if (redirect_c) begin
          pend_d  = target_c;
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (redirect_c) pend_d = target_c;
        if (advance_c) begin
          // A same-cycle redirect supersedes the buffered one
          pc_d    = redirect_c ? target_c : pend_q;
          flush_d = 1'b1;
          state_d = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      pend_q        <= 32'd0;
      fetch_valid_q <= 1'b0;
      flush_q       <= 1'b0;
      align_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_q        <= pend_d;
      fetch_valid_q <= fetch_valid_d;
      flush_q       <= flush_d;
      align_err_q   <= align_err_d;
    end
  end

  assign bus.pc_o          = pc_q;
  assign bus.fetch_valid_o = fetch_valid_q;
  assign bus.flush_o       = flush_q;
  assign bus.align_err_o   = align_err_q;

`ifdef PC_BRANCH_STATS_EN
  logic [CNT_W-1:0] taken_q;
  logic [CNT_W-1:0] not_taken_q;

  // Saturating branch outcome counters, independent of stall/advance
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      taken_q     <= '0;
      not_taken_q <= '0;
    end else if (bus.resolve_valid_i & bus.branch_i) begin
      if (bus.branch_result_i) begin
        if (taken_q != {CNT_W{1'b1}}) taken_q <= taken_q + CNT_W'(1);
      end else begin
        if (not_taken_q != {CNT_W{1'b1}}) not_taken_q <= not_taken_q + CNT_W'(1);
      end
    end
  end

  assign bus.taken_cnt_o     = taken_q;
  assign bus.not_taken_cnt_o = not_taken_q;
`else
  assign bus.taken_cnt_o     = {CNT_W{1'b0}};
  assign bus.not_taken_cnt_o = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/pc_update_unit.md
Name: pc_update_unit

Overview:
- Program-counter stage directly downstream of the branch-decision mux in the single-cycle CPU.
- Consumes the mux's taken/not-taken result plus jump/jr controls and computes the next PC.
- Holds the PC register and presents it to instruction memory under a valid/ready handshake.
- Buffers a resolved redirect while fetch is stalled, and pulses a flush when a redirect lands.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of the optional branch statistics counters.

Ports:
- clk_i  in  1  system clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- fetch_ready_i  in  1  instruction memory accepts pc_o this cycle.
- stall_i  in  1  hazard hold; blocks PC advance.
- resolve_valid_i  in  1  control inputs below are valid this cycle.
- branch_i  in  1  resolved instruction is a conditional branch.
- branch_result_i  in  1  branch-mux decision; 1 = taken.
- jump_i  in  1  j/jal.
- jr_i  in  1  jump-register.
- imm_i  in  32  sign-extended branch offset, in words.
- jump_target_i  in  26  instruction[25:0].
- rs_data_i  in  32  register value for jr.
- pc_o  out  32  current fetch address.
- fetch_valid_o  out  1  pc_o is a valid request.
- flush_o  out  1  one-cycle pulse: redirect applied, discard wrong-path instruction.
- align_err_o  out  1  one-cycle pulse: jr target had bits[1:0] != 0.
- taken_cnt_o  out  CNT_W  taken-branch count (optional feature).
- not_taken_cnt_o  out  CNT_W  not-taken-branch count (optional feature).

Behaviour:
- Reset (rst_i=0, asynchronous):
  - pc_o=RESET_PC.
  - State=BOOT.
  - fetch_valid_o, flush_o and align_err_o are 0.
  - Pending register is cleared.
  - Counters are 0.
- States:
  - BOOT: exactly one cycle after reset release, then RUN; fetch_valid_o=1 from RUN onward.
  - RUN: normal operation.
  - PENDING: a redirect is buffered and waiting for the PC to advance.
- advance = fetch_valid_o & fetch_ready_i & ~stall_i.
- Target arithmetic (all mod 2^32, wrap-around silent):
  - pc4 = pc_o+4.
  - Branch target = pc4 + (imm_i<<2).
  - Jump target = {pc4[31:28], jump_target_i, 2'b00}.
  - jr target = {rs_data_i[31:2], 2'b00}.
- Redirect exists when resolve_valid_i & (jr_i | jump_i | (branch_i & branch_result_i)).
- Priority when several are set: jr_i > jump_i > taken branch.
- RUN:
  - advance & redirect: pc_o <= target; flush_o=1 next cycle.
  - advance & no redirect: pc_o <= pc4.
  - ~advance & redirect: latch target into the pending register; go to PENDING; pc_o holds.
  - ~advance & no redirect: hold.
- PENDING:
  - New redirect: overwrites the pending target (latest wins), regardless of advance.
  - On advance: pc_o <= pending (or the newer target if one arrives the same cycle); flush_o=1 next cycle; return to RUN.
  - resolve_valid_i with no redirect: no effect.
- align_err_o:
  - Pulses one cycle after any jr resolve with rs_data_i[1:0] != 0.
  - Target is still used with the low bits forced to 0.
- stall_i and fetch_ready_i are both honoured. Either blocking advance holds pc_o; fetch_valid_o stays 1.
- Reset asserted mid-PENDING discards the buffered target.

Optional Feature:
- Macro: PC_BRANCH_STATS_EN.
- Defined:
  - On each resolve_valid_i & branch_i, increment taken_cnt_o if branch_result_i=1, else not_taken_cnt_o.
  - Counters saturate at 2^CNT_W-1.
  - Counting is independent of stall or advance.
- Undefined:
  - Both ports are driven constant 0.
  - No counter flops are synthesised.

Test Plan:
1. Reset release with fetch_ready_i=1, stall_i=0:
   - pc_o=0x0 and fetch_valid_o=0 during BOOT.
   - Then pc_o=0x0, 0x4, 0x8 on successive cycles.
2. pc=0x100, taken branch, imm_i=0xFFFF_FFFC, advance:
   - Next pc_o=0x0F4.
   - flush_o=1 for exactly one cycle.
3. pc=0x200, taken branch, imm_i=0x10, stall_i=1 for 3 cycles:
   - pc_o holds 0x200 in state PENDING.
   - After stall drops, pc_o=0x244 and flush_o pulses.
4. While PENDING with target 0x244, jump_i with jump_target_i=0x40:
   - Pending is overwritten.
   - After advance, pc_o=0x0000_0100.
5. Same cycle: jr_i=1 with rs_data_i=0x1003, jump_i=1, branch taken:
   - pc_o=0x1000.
   - align_err_o=1 for one cycle.
6. PC_BRANCH_STATS_EN defined, CNT_W=2, 5 taken + 1 not-taken resolves:
   - taken_cnt_o=3 (saturated), not_taken_cnt_o=1.
   - With the macro undefined, both outputs read 0.
